// File: rtl/cv32e40x_xif_scoreboard.sv
// Pending-write scoreboard for instructions offloaded over XIF.
// Flags RAW/WAW hazards for the ID-stage instruction against outstanding writes.
module cv32e40x_xif_scoreboard #(
    parameter int DEPTH                  = 4,
    parameter int X_ID_WIDTH             = 4,
    parameter int REGFILE_NUM_READ_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  logic [X_ID_WIDTH-1:0]               issue_id_i,
    input  logic                                issue_we_i,
    input  logic [4:0]                          issue_rd_i,
    input  logic                                result_valid_i,
    input  logic [X_ID_WIDTH-1:0]               result_id_i,
    input  logic                                result_we_i,
    input  logic                                kill_all_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0]   rf_re_id_i,
    input  logic [5*REGFILE_NUM_READ_PORTS-1:0] rf_raddr_id_i,
    input  logic                                rf_we_id_i,
    input  logic [4:0]                          rf_waddr_id_i,
    output logic                                raw_stall_o,
    output logic                                waw_stall_o,
    output logic [$clog2(DEPTH+1)-1:0]          outstanding_o,
    output logic                                empty_o,
    output logic                                id_err_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [DEPTH-1:0]      we_q;
    logic [X_ID_WIDTH-1:0] id_q [DEPTH];
    logic [4:0]            rd_q [DEPTH];
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  err_q;
    logic                  err_d;

    logic                  full;
    logic                  issue_fire;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  res_hit;
    logic [IDX_W-1:0]      res_idx;
    logic                  dup_hit;

    assign full          = &valid_q;
    assign issue_ready_o = !full;
    assign issue_fire    = issue_valid_i && !full;

    // Reverse scan so the lowest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        res_hit    = 1'b0;
        res_idx    = '0;
        dup_hit    = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (valid_q[i] && id_q[i] == result_id_i) begin
                res_hit = 1'b1;
                res_idx = IDX_W'(i);
            end
            if (valid_q[i] && id_q[i] == issue_id_i) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        if (kill_all_i) begin
            valid_d = '0;
        end else begin
            if (result_valid_i) begin
                if (!res_hit) begin
                    err_d = 1'b1;
                end else begin
                    valid_d[res_idx] = 1'b0;
                    if (we_q[res_idx] != result_we_i) begin
                        err_d = 1'b1;
                    end
                end
            end
            if (issue_fire && free_found) begin
                valid_d[free_idx] = 1'b1;
                if (dup_hit) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            we_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i] <= '0;
                rd_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (issue_fire && free_found && !kill_all_i) begin
                id_q[free_idx] <= issue_id_i;
                rd_q[free_idx] <= issue_rd_i;
                we_q[free_idx] <= issue_we_i;
            end
        end
    end

    // x0 is never a real dependency.
    always_comb begin
        raw_stall_o = 1'b0;
        waw_stall_o = 1'b0;
        for (int p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rf_re_id_i[p] && rf_raddr_id_i[5*p +: 5] != 5'd0 &&
                    valid_q[i] && we_q[i] &&
                    rd_q[i] == rf_raddr_id_i[5*p +: 5]) begin
                    raw_stall_o = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (rf_we_id_i && rf_waddr_id_i != 5'd0 &&
                valid_q[i] && we_q[i] && rd_q[i] == rf_waddr_id_i) begin
                waw_stall_o = 1'b1;
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign empty_o       = (cnt_q == '0);
    assign id_err_o      = err_q;

endmodule

// File: doc/cv32e40x_xif_scoreboard.md
Name: cv32e40x_xif_scoreboard

Overview:
- Tracks register writes that are still pending from instructions offloaded over the XIF interface. The write is issued when the instruction is offloaded and retired when the coprocessor result returns.
- Raises read-after-write (RAW) and write-after-write (WAW) stall requests for the instruction in ID. These requests feed the controller's hazard/stall logic.
- Sits between the ID-stage offload issue path and the XIF result interface.

Parameters:
- DEPTH, 4, number of outstanding offloaded instructions tracked (2..8).
- X_ID_WIDTH, 4, width of the XIF instruction id.
- REGFILE_NUM_READ_PORTS, 2, number of ID read ports checked.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- issue_valid_i  input  1  offload accepted by the coprocessor this cycle
- issue_ready_o  output  1  scoreboard can accept an entry
- issue_id_i  input  X_ID_WIDTH  id of the offloaded instruction
- issue_we_i  input  1  offloaded instruction writes rd
- issue_rd_i  input  5  destination register
- result_valid_i  input  1  XIF result handshake fires
- result_id_i  input  X_ID_WIDTH  id of the returning result
- result_we_i  input  1  result writes register file
- kill_all_i  input  1  pipeline flush; drop all entries
- rf_re_id_i  input  REGFILE_NUM_READ_PORTS  ID read enables
- rf_raddr_id_i  input  5*REGFILE_NUM_READ_PORTS  ID read addresses, packed
- rf_we_id_i  input  1  ID instruction writes rd
- rf_waddr_id_i  input  5  ID destination register
- raw_stall_o  output  1  ID read hits a pending write
- waw_stall_o  output  1  ID write hits a pending write
- outstanding_o  output  $clog2(DEPTH+1)  number of valid entries
- empty_o  output  1  no valid entries
- id_err_o  output  1  sticky: result id not found, or duplicate issue id

Behaviour:
- Storage: DEPTH entries, each {valid, id, we, rd}. All valid bits reset to 0; id_err_o resets to 0.
- Reset values of outputs: issue_ready_o=1, empty_o=1, outstanding_o=0, stalls=0.
- Reset asserted mid-operation clears all entries immediately (asynchronous).
- Issue:
  - When issue_valid_i && issue_ready_o, write the lowest-index free entry at the clock edge.
  - Entry becomes visible to the stall logic in the next cycle.
  - issue_ready_o = !full, computed from registered state only; it does not depend on a same-cycle result.
  - issue_valid_i while !issue_ready_o is ignored.
- Result:
  - When result_valid_i, clear the valid entry whose id equals result_id_i at the clock edge.
  - If no valid entry matches, set id_err_o. Nothing else changes.
  - result_we_i does not affect clearing. It is only checked against the entry's we field; a mismatch sets id_err_o.
- Duplicate id: issuing an id already held in a valid entry sets id_err_o and still allocates the entry.
- Issue and result in the same cycle:
  - Both take effect.
  - The result cannot match the entry being issued that cycle (no bypass), so the result with the same id reports id_err_o.
  - When full, the result frees a slot and issue_ready_o rises in the next cycle.
- kill_all_i has priority over issue and result in the same cycle:
  - all valid bits clear; no error is flagged;
  - outstanding_o is 0 in the next cycle.
- raw_stall_o, combinational: set if any port i satisfies all of:
  - rf_re_id_i[i] set;
  - raddr[i] != 0;
  - some valid entry has we=1 and rd equal to raddr[i].
- waw_stall_o, combinational: set if all of:
  - rf_we_id_i set;
  - rf_waddr_id_i != 0;
  - some valid entry has we=1 and rd equal to rf_waddr_id_i.
- The stall outputs use registered state only. No combinational path from the issue_* or result_* inputs.
- outstanding_o is the registered popcount of the valid bits; empty_o = (outstanding_o==0).
- id_err_o clears only on reset.

Test Plan:
- Reset, then issue id=3 rd=x5 we=1; the next cycle ID reads x5 on port 1 -> raw_stall_o=1 and outstanding_o=1. After result id=3 -> raw_stall_o=0 and empty_o=1 one cycle later.
- Issue DEPTH=4 entries (ids 0..3) -> issue_ready_o=0. A 5th issue_valid_i is ignored. Result id=1 together with issue_valid_i -> the 5th issue is still not accepted; issue_ready_o=1 the next cycle.
- Issue rd=x0 we=1, then ID reads and writes x0 -> both stalls 0. Issue we=0 rd=x7, then ID reads x7 -> raw_stall_o=0.
- ID writes x9 while an entry holds rd=x9 -> waw_stall_o=1 and raw_stall_o=0.
- Result id=6 with no entry holding it -> id_err_o=1 and stays 1; outstanding_o is unchanged.
- 3 entries valid; kill_all_i together with issue_valid_i and result_valid_i -> outstanding_o=0 and id_err_o=0 next cycle. Asserting rst mid-stream clears everything asynchronously.
